// File: rtl/keyword_led_sequencer.sv
// Keyword-to-LED indicator: solid hold, then an off/on blink train, then dark.
// Optional hit counter enabled by defining KWLED_HIT_COUNT_EN.
module keyword_led_sequencer #(
    parameter int KW_W         = 4,
    parameter int NUM_KW       = 15,
    parameter int NUM_LEDS     = 4,
    parameter int HOLD_CYCLES  = 50000000,
    parameter int BLINK_HALF   = 12500000,
    parameter int BLINK_PULSES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                kw_valid,
    input  logic [KW_W-1:0]     kw_index,
    output logic                kw_ready,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic [KW_W-1:0]     active_kw,
    output logic                err_pulse
`ifdef KWLED_HIT_COUNT_EN
    ,
    input  logic                hit_clr,
    output logic [7:0]          hit_count
`endif
);

    localparam int CNT_MAX = (HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PULSE_W = (BLINK_PULSES == 0) ? 1 : $clog2(2 * BLINK_PULSES + 1);

    localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   HALF_LOAD  = CNT_W'(BLINK_HALF - 1);
    localparam logic [PULSE_W-1:0] LAST_HALF  = PULSE_W'((BLINK_PULSES == 0) ? 0 : 2 * BLINK_PULSES - 1);
    localparam logic [KW_W:0]      LEDS_K     = (KW_W + 1)'(NUM_LEDS);
    localparam logic [KW_W:0]      NUM_KW_K   = (KW_W + 1)'(NUM_KW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLINK = 2'd2
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [CNT_W-1:0]      hold_cnt_r, hold_cnt_nxt_s;
    logic [CNT_W-1:0]      half_cnt_r, half_cnt_nxt_s;
    logic [PULSE_W-1:0]    pulse_cnt_r, pulse_cnt_nxt_s;
    logic [NUM_LEDS-1:0]   sel_r, sel_nxt_s;
    logic [NUM_LEDS-1:0]   led_nxt_s;
    logic [KW_W-1:0]       active_nxt_s;
    logic                  err_nxt_s;

    logic [KW_W:0]         kw_ext_s;
    logic [KW_W:0]         kw_m1_s;
    logic [KW_W:0]         ch_full_s;
    logic [NUM_LEDS-1:0]   sel_s;
    logic                  offer_s;
    logic                  kw_zero_s;
    logic                  kw_over_s;
    logic                  accept_s;

    // Offer classification and keyword-to-channel one-hot decode (extra bit keeps index-1 from wrapping)
    always_comb begin
        kw_ext_s  = {1'b0, kw_index};
        kw_m1_s   = kw_ext_s - (KW_W + 1)'(1);
        ch_full_s = kw_m1_s % LEDS_K;
        sel_s     = {NUM_LEDS{1'b0}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            sel_s[i] = (ch_full_s == (KW_W + 1)'(i));
        end
        offer_s   = kw_valid && kw_ready;
        kw_zero_s = (kw_index == {KW_W{1'b0}});
        kw_over_s = (kw_ext_s > NUM_KW_K);
        accept_s  = offer_s && !kw_zero_s && !kw_over_s;
    end

    // Next-state and next-output logic; an accept always wins over SHOW expiry
    always_comb begin
        state_nxt_s     = state_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        half_cnt_nxt_s  = half_cnt_r;
        pulse_cnt_nxt_s = pulse_cnt_r;
        sel_nxt_s       = sel_r;
        led_nxt_s       = led;
        active_nxt_s    = active_kw;
        err_nxt_s       = offer_s && kw_over_s;

        case (state_r)
            IDLE: begin
                led_nxt_s = {NUM_LEDS{1'b0}};
                if (accept_s) begin
                    state_nxt_s    = SHOW;
                    led_nxt_s      = sel_s;
                    sel_nxt_s      = sel_s;
                    active_nxt_s   = kw_index;
                    hold_cnt_nxt_s = HOLD_LOAD;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            SHOW: begin
                if (accept_s) begin
                    led_nxt_s      = sel_s;
                    sel_nxt_s      = sel_s;
                    active_nxt_s   = kw_index;
                    hold_cnt_nxt_s = HOLD_LOAD;
                end else if (hold_cnt_r == {CNT_W{1'b0}}) begin
                    led_nxt_s = {NUM_LEDS{1'b0}};
                    if (BLINK_PULSES == 0) begin
                        state_nxt_s  = IDLE;
                        active_nxt_s = {KW_W{1'b0}};
                    end else begin
                        state_nxt_s     = BLINK;
                        half_cnt_nxt_s  = HALF_LOAD;
                        pulse_cnt_nxt_s = {PULSE_W{1'b0}};
                    end
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r - CNT_W'(1);
                end
            end
            BLINK: begin
                // pulse_cnt_r is the half-period index: even halves dark, odd halves lit
                if (half_cnt_r == {CNT_W{1'b0}}) begin
                    if (pulse_cnt_r == LAST_HALF) begin
                        state_nxt_s     = IDLE;
                        led_nxt_s       = {NUM_LEDS{1'b0}};
                        active_nxt_s    = {KW_W{1'b0}};
                        pulse_cnt_nxt_s = {PULSE_W{1'b0}};
                    end else begin
                        pulse_cnt_nxt_s = pulse_cnt_r + PULSE_W'(1);
                        half_cnt_nxt_s  = HALF_LOAD;
                        if (pulse_cnt_r[0] == 1'b0) begin
                            led_nxt_s = sel_r;
                        end else begin
                            led_nxt_s = {NUM_LEDS{1'b0}};
                        end
                    end
                end else begin
                    half_cnt_nxt_s = half_cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                led_nxt_s       = {NUM_LEDS{1'b0}};
                active_nxt_s    = {KW_W{1'b0}};
                hold_cnt_nxt_s  = {CNT_W{1'b0}};
                half_cnt_nxt_s  = {CNT_W{1'b0}};
                pulse_cnt_nxt_s = {PULSE_W{1'b0}};
                sel_nxt_s       = {NUM_LEDS{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs; ready/busy are decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            hold_cnt_r  <= {CNT_W{1'b0}};
            half_cnt_r  <= {CNT_W{1'b0}};
            pulse_cnt_r <= {PULSE_W{1'b0}};
            sel_r       <= {NUM_LEDS{1'b0}};
            led         <= {NUM_LEDS{1'b0}};
            active_kw   <= {KW_W{1'b0}};
            err_pulse   <= 1'b0;
            busy        <= 1'b0;
            kw_ready    <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            half_cnt_r  <= half_cnt_nxt_s;
            pulse_cnt_r <= pulse_cnt_nxt_s;
            sel_r       <= sel_nxt_s;
            led         <= led_nxt_s;
            active_kw   <= active_nxt_s;
            err_pulse   <= err_nxt_s;
            busy        <= (state_nxt_s != IDLE);
            kw_ready    <= (state_nxt_s != BLINK);
        end
    end

`ifdef KWLED_HIT_COUNT_EN
    // Saturating accept counter; clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= 8'd0;
        end else if (hit_clr) begin
            hit_count <= 8'd0;
        end else if (accept_s && (hit_count != 8'hFF)) begin
            hit_count <= hit_count + 8'd1;
        end else begin
            hit_count <= hit_count;
        end
    end
`endif

endmodule

// File: tb/tb_keyword_led_sequencer.sv
// Directed bench for keyword_led_sequencer (HOLD=8, HALF=2, PULSES=2, 4 LEDs, 10 keywords).
module tb_keyword_led_sequencer;

    logic       clk;
    logic       rst;
    logic       kw_valid;
    logic [3:0] kw_index;
    logic       kw_ready;
    logic [3:0] led;
    logic       busy;
    logic [3:0] active_kw;
    logic       err_pulse;
`ifdef KWLED_HIT_COUNT_EN
    logic       hit_clr;
    logic [7:0] hit_count;
`endif

    int n_vec;
    int n_err;

    keyword_led_sequencer #(
        .KW_W(4), .NUM_KW(10), .NUM_LEDS(4),
        .HOLD_CYCLES(8), .BLINK_HALF(2), .BLINK_PULSES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .kw_valid(kw_valid), .kw_index(kw_index), .kw_ready(kw_ready),
        .led(led), .busy(busy), .active_kw(active_kw), .err_pulse(err_pulse)
`ifdef KWLED_HIT_COUNT_EN
        , .hit_clr(hit_clr), .hit_count(hit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (busy == 1'b0) break;
            step();
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Expected led after each edge from accept: 8 solid, then off,off,on,on,off,off,on,on
    logic [3:0] basic_exp [16] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2,
                                   4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2};
    logic [3:0] lock_exp [8]   = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1};

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        kw_valid = 1'b0;
        kw_index = 4'd0;
`ifdef KWLED_HIT_COUNT_EN
        hit_clr  = 1'b0;
`endif
        #12;
        chk("rst_led",   {28'd0, led}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, kw_ready}, 32'd1);
        chk("rst_act",   {28'd0, active_kw}, 32'd0);
        chk("rst_err",   {31'd0, err_pulse}, 32'd0);
        rst = 1'b0;
        step();

        // Basic: kw 6 -> channel 1
        kw_valid = 1'b1; kw_index = 4'd6;
        step();
        kw_valid = 1'b0;
        chk("basic_act", {28'd0, active_kw}, 32'd6);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("basic_led%0d", i), {28'd0, led}, {28'd0, basic_exp[i]});
            chk($sformatf("basic_busy%0d", i), {31'd0, busy}, 32'd1);
            step();
        end
        chk("basic_end_led",  {28'd0, led}, 32'd0);
        chk("basic_end_busy", {31'd0, busy}, 32'd0);
        chk("basic_end_act",  {28'd0, active_kw}, 32'd0);
        chk("basic_end_rdy",  {31'd0, kw_ready}, 32'd1);

        // Retrigger: kw 1, then kw 7 on the fifth SHOW cycle
        kw_valid = 1'b1; kw_index = 4'd1;
        step();
        kw_valid = 1'b0;
        chk("rt_led1", {28'd0, led}, 32'h1);
        step(); step(); step();
        chk("rt_led1b", {28'd0, led}, 32'h1);
        kw_valid = 1'b1; kw_index = 4'd7;
        step();
        kw_valid = 1'b0;
        chk("rt_led7", {28'd0, led}, 32'h4);
        chk("rt_act7", {28'd0, active_kw}, 32'd7);
        for (int i = 0; i < 7; i++) step();
        chk("rt_hold_last", {28'd0, led}, 32'h4);
        step();
        chk("rt_blink_off", {28'd0, led}, 32'h0);
        chk("rt_blink_rdy", {31'd0, kw_ready}, 32'd0);
        wait_idle();

        // Edge indices
        kw_valid = 1'b1; kw_index = 4'd0;
        step();
        kw_valid = 1'b0;
        chk("zero_busy", {31'd0, busy}, 32'd0);
        chk("zero_err",  {31'd0, err_pulse}, 32'd0);
        kw_valid = 1'b1; kw_index = 4'd11;
        step();
        kw_valid = 1'b0;
        chk("over_err",  {31'd0, err_pulse}, 32'd1);
        chk("over_busy", {31'd0, busy}, 32'd0);
        chk("over_led",  {28'd0, led}, 32'd0);
        step();
        chk("over_err_drop", {31'd0, err_pulse}, 32'd0);
        kw_valid = 1'b1; kw_index = 4'd10;
        step();
        kw_valid = 1'b0;
        chk("max_led", {28'd0, led}, 32'h2);
        chk("max_act", {28'd0, active_kw}, 32'd10);
        wait_idle();

        // Blink lockout: kw 5 -> channel 0, offer kw 3 during BLINK
        kw_valid = 1'b1; kw_index = 4'd5;
        step();
        kw_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                kw_valid = 1'b1; kw_index = 4'd3;
            end
            if (i == 3) kw_valid = 1'b0;
            chk($sformatf("lock_led%0d", i), {28'd0, led}, {28'd0, lock_exp[i]});
            chk($sformatf("lock_act%0d", i), {28'd0, active_kw}, 32'd5);
            chk($sformatf("lock_rdy%0d", i), {31'd0, kw_ready}, 32'd0);
            chk($sformatf("lock_err%0d", i), {31'd0, err_pulse}, 32'd0);
            step();
        end
        chk("lock_end_busy", {31'd0, busy}, 32'd0);

        // Accept on the SHOW expiry cycle: kw 4 (ch 3), then kw 9 (ch 0)
        kw_valid = 1'b1; kw_index = 4'd4;
        step();
        kw_valid = 1'b0;
        chk("exp_led4", {28'd0, led}, 32'h8);
        for (int i = 0; i < 7; i++) step();
        kw_valid = 1'b1; kw_index = 4'd9;
        step();
        kw_valid = 1'b0;
        chk("exp_led9", {28'd0, led}, 32'h1);
        chk("exp_rdy",  {31'd0, kw_ready}, 32'd1);
        chk("exp_act",  {28'd0, active_kw}, 32'd9);
        for (int i = 0; i < 7; i++) step();
        chk("exp_hold_last", {28'd0, led}, 32'h1);
        step();
        chk("exp_blink", {31'd0, kw_ready}, 32'd0);
        wait_idle();

        // Asynchronous reset mid-BLINK, then accept on the first cycle after release
        kw_valid = 1'b1; kw_index = 4'd6;
        step();
        kw_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("arst_pre_led", {28'd0, led}, 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_led",  {28'd0, led}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_rdy",  {31'd0, kw_ready}, 32'd1);
        chk("arst_act",  {28'd0, active_kw}, 32'd0);
        #1;
        rst = 1'b0;
        kw_valid = 1'b1; kw_index = 4'd2;
        step();
        kw_valid = 1'b0;
        chk("post_led",  {28'd0, led}, 32'h2);
        chk("post_busy", {31'd0, busy}, 32'd1);
        chk("post_act",  {28'd0, active_kw}, 32'd2);
        wait_idle();

`ifdef KWLED_HIT_COUNT_EN
        // 300 back-to-back accepts saturate; clear beats a same-cycle accept
        kw_valid = 1'b1; kw_index = 4'd1;
        for (int i = 0; i < 300; i++) step();
        chk("hit_sat", {24'd0, hit_count}, 32'd255);
        hit_clr = 1'b1;
        step();
        hit_clr = 1'b0;
        kw_valid = 1'b0;
        chk("hit_clr", {24'd0, hit_count}, 32'd0);
        wait_idle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keyword_led_sequencer.md
Name: keyword_led_sequencer

Overview:
Parametrised LED indicator driven by the Viterbi keyword decoder. It accepts keyword detections over a valid/ready handshake and maps each keyword to one of NUM_LEDS LED channels. The selected LED lights solid for a hold period, then blinks a fixed number of times before going dark. It sits between the Viterbi back-end and the board LED pins, and exports busy/status signals for the top-level debug logic.

Parameters:
KW_W, 4, width of the keyword index
NUM_KW, 15, highest valid keyword index; valid range is 1..NUM_KW
NUM_LEDS, 4, number of LED output channels
HOLD_CYCLES, 50000000, clock cycles of solid-on after a detection; must be >= 1
BLINK_HALF, 12500000, clock cycles per blink half-period; must be >= 1
BLINK_PULSES, 3, number of off/on blink pairs after the hold period; 0 skips BLINK

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
kw_valid  input  1  keyword detection strobe from the Viterbi module
kw_index  input  KW_W  detected keyword index; 0 means no keyword
kw_ready  output  1  sequencer can accept a detection
led  output  NUM_LEDS  LED drive, active-high, at most one bit set
busy  output  1  high whenever state != IDLE
active_kw  output  KW_W  keyword currently being displayed; 0 when idle
err_pulse  output  1  one-cycle pulse when an out-of-range index is offered

Behaviour:
- Reset values (asynchronous): state=IDLE, led=0, busy=0, active_kw=0, err_pulse=0, kw_ready=1, counters=0.
- All outputs are registered. kw_ready is decoded from state: 1 in IDLE and SHOW, 0 in BLINK.
- Accept condition: kw_valid && kw_ready && kw_index!=0 && kw_index<=NUM_KW.
- kw_valid && kw_ready with kw_index==0: ignored, no state change, no err_pulse.
- kw_valid && kw_ready with kw_index>NUM_KW: err_pulse=1 for exactly one cycle, no state change.
- Offers made while kw_ready=0 are dropped silently, with no error.
- Channel select: ch = (kw_index-1) mod NUM_LEDS. Compute in KW_W+1 bits to avoid wrap.
- States: IDLE, SHOW, BLINK.
- IDLE: led=0. On accept at edge N, from edge N: state=SHOW, led=one-hot(ch), active_kw=kw_index, hold counter loaded with HOLD_CYCLES-1.
- SHOW: led held at one-hot(ch); counter decrements each cycle.
  - Accept in SHOW (retrigger): reload the counter, update ch and active_kw; takes effect at the same edge.
  - When the counter reaches 0 with no accept: go to BLINK, or to IDLE if BLINK_PULSES=0. led=0 at that edge.
  - SHOW therefore lasts exactly HOLD_CYCLES cycles from the last accept.
- BLINK: 2*BLINK_PULSES half-periods, each BLINK_HALF cycles, alternating off then on, starting off.
  - Half-period counter plus a pulse counter of width $clog2(2*BLINK_PULSES+1).
  - After the final "on" half-period, go to IDLE with led=0 and active_kw=0.
- Simultaneous accept and SHOW expiry in the same cycle: the accept wins, so the block stays in SHOW and reloads.
- Reset mid-operation: immediately returns all outputs to their reset values. No in-flight keyword is retained.
- Counter widths: $clog2 of max(HOLD_CYCLES, BLINK_HALF)+1. No counter wraps; each is reloaded, never free-running.

Optional Feature:
Macro KWLED_HIT_COUNT_EN.
- Defined: adds output hit_count [7:0]. Reset to 0; incremented on every accept, including retriggers; saturates at 255 and never wraps. Also adds input hit_clr (1 bit), a synchronous clear. hit_clr has priority over an increment in the same cycle.
- Not defined: no hit_count or hit_clr ports and no counter logic. All other behaviour is identical.

Test Plan:
All scenarios use HOLD_CYCLES=8, BLINK_HALF=2, BLINK_PULSES=2, NUM_LEDS=4, NUM_KW=10.
- Basic: accept kw_index=6 -> led=4'b0010 for 8 cycles; then off/on/off/on at 2 cycles each (led 0,0,2,2,0,0,2,2); then led=0, busy=0, active_kw=0. Total busy = 16 cycles.
- Retrigger: kw_index=1, then kw_index=7 on SHOW cycle 5 -> led switches to 4'b0100 at that edge; SHOW lasts 8 more cycles; active_kw=7.
- Edge indices: kw_index=0 -> no change, no err. kw_index=11 -> err_pulse high exactly 1 cycle, state stays IDLE. kw_index=10 -> led=4'b0010.
- Blink lockout: offer kw_index=3 during BLINK -> kw_ready=0, offer dropped, blink sequence completes unchanged. Simultaneous accept on the SHOW expiry cycle -> stays in SHOW.
- Reset: assert rst asynchronously mid-BLINK (between clock edges) -> led=0, busy=0, kw_ready=1 immediately. An accept on the first cycle after rst deasserts works normally.
- KWLED_HIT_COUNT_EN build: 300 accepts -> hit_count=255. hit_clr together with an accept -> hit_count=0.
